// File: rtl/even_parity_uart_tx.sv
// -----------------------------------------------------------------------------
// even_parity_uart_tx
//
// Serial transmitter for parallel words. Each frame is a start bit, the data
// bits LSB first, an even parity bit and a stop bit, every bit held for
// CLKS_PER_BIT clocks. The frame format matches what the even-parity receiver
// on the other side checks.
//
// Build option:
//   EVEN_PARITY_UART_TX_PARITY_EN  defined   -> start, data, parity, stop
//                                  undefined -> start, data, stop (8N1)
//
// Parameters:
//   DATA_WIDTH    data bits per frame
//   CLKS_PER_BIT  clocks per serial bit (>= 2; 434 = 115200 baud at 50 MHz)
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-high reset; abandons any frame in flight
//   iData   word to send, sampled only on the edge that accepts iStart
//   iStart  send request, honoured only while idle (never queued)
//   oTx     serial line, idles high
//   oBusy   high from the start bit through the stop bit
//   oDone   single-cycle pulse in the first idle cycle after the stop bit
// -----------------------------------------------------------------------------
module even_parity_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] iData,
    input  logic                  iStart,
    output logic                  oTx,
    output logic                  oBusy,
    output logic                  oDone
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } TxState;

    TxState                state;
    TxState                stateNext;
    logic [CNT_W-1:0]      baudCnt;
    logic [CNT_W-1:0]      baudCntNext;
    logic [IDX_W-1:0]      bitIdx;
    logic [IDX_W-1:0]      bitIdxNext;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] shiftRegNext;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
    logic                  parityBit;
    logic                  parityBitNext;
`endif
    logic                  txNext;
    logic                  busyNext;
    logic                  doneNext;
    logic                  bitEnd;

    assign bitEnd = (baudCnt == LAST_CNT);

    // Next-state logic. The outputs are computed from the *next* state and
    // the *next* shift register so they can be registered alongside the
    // state and line up with it exactly, keeping oTx/oBusy/oDone glitch-free.
    always_comb begin
        stateNext     = state;
        baudCntNext   = baudCnt;
        bitIdxNext    = bitIdx;
        shiftRegNext  = shiftReg;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
        parityBitNext = parityBit;
`endif
        doneNext      = 1'b0;

        case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext     = START;
                    baudCntNext   = '0;
                    bitIdxNext    = '0;
                    shiftRegNext  = iData;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
                    parityBitNext = ^iData;
`endif
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext   = DATA;
                    baudCntNext = '0;
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCntNext  = '0;
                    shiftRegNext = {1'b0, shiftReg[DATA_WIDTH-1:1]};
                    if (bitIdx == LAST_IDX) begin
                        bitIdxNext = '0;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
                        stateNext  = PARITY;
`else
                        stateNext  = STOP;
`endif
                    end else begin
                        bitIdxNext = bitIdx + IDX_W'(1);
                    end
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    stateNext   = STOP;
                    baudCntNext = '0;
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    stateNext   = IDLE;
                    baudCntNext = '0;
                    doneNext    = 1'b1;
                end else begin
                    baudCntNext = baudCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftRegNext[0];
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
            PARITY:  txNext = parityBitNext;
`endif
            default: txNext = 1'b1;
        endcase

        busyNext = (stateNext != IDLE);
    end

    // State, datapath and output registers. Reset drops everything back to an
    // idle, high line so a half-sent frame is simply abandoned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
            oTx       <= 1'b1;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudCntNext;
            bitIdx    <= bitIdxNext;
            shiftReg  <= shiftRegNext;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
            parityBit <= parityBitNext;
`endif
            oTx       <= txNext;
            oBusy     <= busyNext;
            oDone     <= doneNext;
        end
    end

endmodule

// File: tb/tb_even_parity_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_even_parity_uart_tx
//
// Scoreboard bench for even_parity_uart_tx with CLKS_PER_BIT = 4. Stimulus
// pushes each accepted word and its accept cycle into a queue; a line monitor
// acting as a receiver captures every frame off oTx, pops the expectation and
// checks start timing, bit widths, bit values, parity and the oDone pulse.
// Follows EVEN_PARITY_UART_TX_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_even_parity_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 3;
`else
    localparam int FRAME_BITS = DW + 2;
`endif
    localparam int FRAME_LEN = FRAME_BITS * CPB;

    logic          clk;
    logic          reset;
    logic [DW-1:0] iData;
    logic          iStart;
    logic          oTx;
    logic          oBusy;
    logic          oDone;

    typedef struct {
        logic [DW-1:0] data;
        int            acceptCycle;
    } ExpFrame;

    ExpFrame expQ[$];
    int      cycleNo = 0;
    int      nVectors = 0;
    int      nMiscompares = 0;

    even_parity_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .iData (iData),
        .iStart(iStart),
        .oTx   (oTx),
        .oBusy (oBusy),
        .oDone (oDone)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used as the common time base for stimulus and monitor.
    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual != expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    // Reference frame: bit i of the serial frame for word d.
    function automatic int expBit(input logic [DW-1:0] d, input int i);
        if (i == 0) return 0;
        if (i <= DW) return int'(d[i-1]);
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
        if (i == DW + 1) return $countones(d) % 2;
`endif
        return 1;
    endfunction

    // Receiver-style monitor: waits for the line to drop, captures one full
    // frame of samples, then compares it against the oldest expectation.
    int      lineBuf[FRAME_LEN];
    int      pos = 0;
    bit      inFrame = 0;
    bit      haveExp = 0;
    int      doneCycle = -1;
    ExpFrame cur;

    always @(negedge clk) begin
        if (reset) begin
            inFrame   = 0;
            pos       = 0;
            doneCycle = -1;
            expQ.delete();
        end else begin
            if (!inFrame) begin
                checkOutput("donePulse", int'(oDone), int'(cycleNo == doneCycle));
                if (oTx == 1'b0) begin
                    inFrame = 1;
                    pos     = 0;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedFrame", 1, 0);
                        haveExp = 0;
                    end else begin
                        cur       = expQ.pop_front();
                        haveExp   = 1;
                        doneCycle = cur.acceptCycle + FRAME_LEN;
                        checkOutput("startLatency", cycleNo, cur.acceptCycle);
                    end
                end else begin
                    checkOutput("idleBusy", int'(oBusy), 0);
                end
            end else begin
                checkOutput("doneInFrame", int'(oDone), 0);
            end

            if (inFrame) begin
                lineBuf[pos] = int'(oTx);
                pos++;
                checkOutput("busyInFrame", int'(oBusy), 1);
                if (pos == FRAME_LEN) begin
                    inFrame = 0;
                    if (haveExp) begin
                        int            ones;
                        logic [DW-1:0] rx;
                        ones = 0;
                        rx   = '0;
                        for (int b = 0; b < FRAME_BITS; b++) begin
                            int stable;
                            stable = 0;
                            for (int s = 0; s < CPB; s++)
                                if (lineBuf[b*CPB+s] == lineBuf[b*CPB]) stable++;
                            checkOutput("bitWidth", stable, CPB);
                            checkOutput("frameBit", lineBuf[b*CPB], expBit(cur.data, b));
                            if (b >= 1 && b <= DW) rx[b-1] = lineBuf[b*CPB][0];
                            if (b >= 1 && b < FRAME_BITS - 1) ones += lineBuf[b*CPB];
                        end
                        checkOutput("rxData", int'(rx), int'(cur.data));
`ifdef EVEN_PARITY_UART_TX_PARITY_EN
                        checkOutput("rxParityErr", ones % 2, 0);
`else
                        checkOutput("rxOnes", ones, $countones(cur.data));
`endif
                    end
                end
            end
        end
    end

    // Wait (at negedges) until the transmitter is idle, bounded.
    task automatic waitIdle();
        int guard;
        guard = 0;
        while (oBusy && guard < 3 * FRAME_LEN) begin
            @(negedge clk);
            guard++;
        end
        if (oBusy) checkOutput("idleTimeout", 1, 0);
    endtask

    // Issue one request once idle and record the expected frame.
    task automatic applyStimulus(input logic [DW-1:0] w, input bit holdStart, output int acc);
        waitIdle();
        iData  = w;
        iStart = 1'b1;
        acc    = cycleNo + 1;
        expQ.push_back('{data: w, acceptCycle: acc});
        @(negedge clk);
        if (!holdStart) iStart = 1'b0;
    endtask

    initial begin
        int acc;
        reset  = 1'b1;
        iData  = '0;
        iStart = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetTx", int'(oTx), 1);
        checkOutput("resetBusy", int'(oBusy), 0);
        checkOutput("resetDone", int'(oDone), 0);
        reset = 1'b0;

        // Quiet line after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idleTx", int'(oTx), 1);
        end

        // Directed words: balanced and odd ones count.
        applyStimulus(8'hA5, 1'b0, acc);
        applyStimulus(8'h07, 1'b0, acc);

        // Request mid-frame must be dropped; only the 8'h00 frame appears.
        applyStimulus(8'h00, 1'b0, acc);
        repeat (15) @(negedge clk);
        iData  = 8'hFF;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        iData  = 8'h11;

        // Reset during data bit 3, then a clean frame.
        applyStimulus(8'hC3, 1'b0, acc);
        while (cycleNo < acc + 4 * CPB + 1) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncResetTx", int'(oTx), 1);
        checkOutput("asyncResetBusy", int'(oBusy), 0);
        checkOutput("asyncResetDone", int'(oDone), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(8'h3C, 1'b0, acc);

        // Random words with random gaps, some back-to-back with iStart held.
        for (int i = 0; i < 14; i++) begin
            bit hold;
            hold = ($urandom_range(0, 1) == 1);
            applyStimulus(8'($urandom), hold, acc);
            if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        iStart = 1'b0;

        // Drain.
        for (int g = 0; g < 4 * FRAME_LEN && (expQ.size() != 0 || oBusy); g++)
            @(negedge clk);
        checkOutput("drainPending", expQ.size(), 0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/even_parity_uart_tx.md
# even_parity_uart_tx

- Serial transmitter for 8-bit words using the same frame format the receive-side even-parity checker validates: start bit, data LSB first, even parity bit, stop bit.
- Latches a parallel word on a start strobe, generates the parity bit, and shifts the frame out on a single line at a fixed bit period.
- Sits between the core's parallel data path and the TX pin.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLKS_PER_BIT, 434, clock cycles per serial bit; must be ≥ 2 (434 gives 115200 baud at 50 MHz).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- iData  input  DATA_WIDTH  word to send; sampled only on the accepting edge.
- iStart  input  1  send request; accepted only in IDLE.
- oTx  output  1  serial line; idles high.
- oBusy  output  1  high while a frame is in flight (START through STOP).
- oDone  output  1  one-cycle pulse after the stop bit completes.

## Operation
- States:
  - IDLE: oTx=1.
  - START: oTx=0.
  - DATA: oTx = shift_reg[0].
  - PARITY: oTx = parity bit.
  - STOP: oTx=1.
- Parity is ^iData, computed at accept time, so the total count of ones over data plus parity is even.
- IDLE → START when iStart=1 on an edge.
  - On that edge, iData is loaded into the shift register and the parity bit is registered.
- Each non-IDLE state lasts exactly CLKS_PER_BIT cycles.
  - A baud counter runs 0..CLKS_PER_BIT-1 and clears on every state change and every bit boundary.
- DATA covers DATA_WIDTH bits.
  - At the end of each bit period, the shift register shifts right and the bit index increments.
  - After bit DATA_WIDTH-1 the state goes to PARITY.
- PARITY → STOP → IDLE.
  - The STOP → IDLE edge sets oDone for exactly one cycle.
- oTx, oBusy and oDone are driven from registers, so they are glitch-free.
- Behaviour while busy:
  - iStart while busy is ignored; requests are not queued.
  - iData changes while busy have no effect on the frame in flight.
- Reset, at any time including mid-frame, asynchronously forces:
  - state=IDLE, oTx=1, oBusy=0, oDone=0;
  - counters and shift register cleared.
  - Any partial frame is abandoned; the line is held high.

## Timing
- Reset values: oTx=1, oBusy=0, oDone=0.
- Frame acceptance and start bit:
  - iStart is sampled on edge N.
  - oTx=0 and oBusy=1 from cycle N+1.
  - The start bit occupies cycles N+1 .. N+CLKS_PER_BIT.
- Data bit k (k = 0..DATA_WIDTH-1) occupies cycles N+1+(k+1)·CLKS_PER_BIT onward, for CLKS_PER_BIT cycles.
- Frame length is (DATA_WIDTH+3)·CLKS_PER_BIT cycles; 11·CLKS_PER_BIT at the defaults.
- Frame end:
  - oBusy falls and oDone rises on the same edge that ends the stop bit.
  - oDone is high for one cycle, during which the state is IDLE.
- Back-to-back:
  - iStart held high continuously is accepted in the oDone cycle.
  - This gives exactly one idle-high cycle between the stop bit and the next start bit.

## Configuration
- Macro: EVEN_PARITY_UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is present.
  - Frame length is (DATA_WIDTH+3)·CLKS_PER_BIT.
  - This matches the receiver's parity check.
- Undefined:
  - The PARITY state and parity register are removed; DATA goes directly to STOP.
  - Frame length is (DATA_WIDTH+2)·CLKS_PER_BIT (8N1 framing).
  - All other timing is unchanged.

## Test plan
All scenarios use CLKS_PER_BIT=4 and the macro defined, unless stated otherwise.
- Reset, then idle 20 cycles → oTx=1, oBusy=0, oDone=0 throughout.
- Send 8'hA5 (four ones) → line shows 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 4 cycles wide; oDone pulses once at cycle 44 after accept.
- Send 8'h07 (three ones) → parity bit 1; a receiver model reconstructs 8'h07 with no parity error.
- Pulse iStart with 8'hFF mid-frame of a 8'h00 transmission → second request ignored; only the 8'h00 frame is seen; oBusy never drops early.
- Assert reset during data bit 3 → oTx=1 and oBusy=0 immediately (asynchronously); a new iStart with 8'h3C then produces a clean full frame.
- Macro undefined, send 8'hA5 → 40-cycle frame with no parity bit; stop bit follows data bit 7 directly.
